lap_stash: RTL and testbench
============================

Name: lap_stash

Overview:
- Parametrised circular sample store for the stopwatch lab; the successor to the fixed 8-bit single-direction stash.
- Stores up to DEPTH samples of WIDTH bits and tracks occupancy.
- Lets the user browse the stored samples forwards and backwards. The exposed index is limited to the valid entries, not to DEPTH.
- Full-buffer handling is selectable: overwrite the oldest entry, or drop the new sample and flag the drop.

Parameters:
- WIDTH, 8: bits per sample.
- DEPTH, 5: number of storage slots, minimum 2.
- OVERWRITE, 1: 1 = writing when full replaces the oldest entry; 0 = writing when full is dropped and flagged.
- Derived: PTR_WIDTH = $clog2(DEPTH), CNT_WIDTH = $clog2(DEPTH+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_in  in  WIDTH  sample to store.
- sample_in_valid  in  1  store sample_in this cycle.
- next_sample  in  1  move the view one entry towards newer.
- prev_sample  in  1  move the view one entry towards older.
- clear  in  1  synchronous flush of all stored entries.
- sample_out  out  WIDTH  exposed sample (combinational).
- view_idx  out  PTR_WIDTH  logical index of the exposed entry; 0 = oldest.
- count  out  CNT_WIDTH  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  one-cycle pulse: a write was dropped.

Behaviour:
- State: memory[DEPTH], head (physical slot of oldest entry), count, view_idx, overflow.
  - All addresses are computed modulo DEPTH using wrap-around increment/decrement logic, not a power-of-2 mask.
- Reset (reset==0, asynchronous, any time including mid-write):
  - head=0, count=0, view_idx=0, overflow=0, all memory slots=0.
  - Resulting outputs: sample_out=0 when sample_in_valid==0; empty=1, full=0.
- Priority each cycle: clear > write > navigation.
- clear==1:
  - count=0, head=0, view_idx=0, overflow=0.
  - Memory contents are not erased.
  - sample_in_valid and navigation are ignored that cycle.
- Write (sample_in_valid==1, clear==0, count<DEPTH):
  - memory[(head+count) mod DEPTH] <= sample_in.
  - count <= count+1.
  - view_idx <= count, i.e. the new entry becomes the exposed one.
- Write when full, OVERWRITE=1:
  - memory[head] <= sample_in.
  - head <= (head+1) mod DEPTH.
  - count stays DEPTH.
  - view_idx <= DEPTH-1.
- Write when full, OVERWRITE=0:
  - memory, head, count and view_idx are unchanged.
  - overflow=1 for the next cycle only.
- Navigation (applies only when sample_in_valid==0 and clear==0):
  - next_sample and prev_sample both high: no move.
  - count==0: view_idx stays 0.
  - next_sample alone: view_idx <= (view_idx==count-1) ? 0 : view_idx+1.
  - prev_sample alone: view_idx <= (view_idx==0) ? count-1 : view_idx-1.
  - Navigation requests arriving during a write cycle are discarded, not queued.
- Inputs are level-sampled: a level held high for N cycles gives N moves or N writes. Edge detection is the caller's responsibility.
- sample_out (combinational):
  - sample_in_valid==1: sample_in (bypass, zero latency).
  - else if empty: 0.
  - else memory[(head+view_idx) mod DEPTH].
- Latency:
  - A stored or navigated value appears on sample_out the cycle after the triggering edge.
  - count, full, empty and view_idx are registered or derived directly from registers, so they update on the same edge.
- overflow is cleared on every cycle without a dropped write.
- Invariant: view_idx < count whenever count > 0. The bench asserts this every cycle.

Test Plan:
- Reset then idle, WIDTH=8 DEPTH=5 -> sample_out=0, count=0, empty=1, full=0, overflow=0; next_sample pulses leave view_idx=0.
- Write 0x11,0x22,0x33 (one cycle each) -> sample_out shows each value during its write cycle; afterwards count=3, view_idx=2, sample_out=0x33. Then 3 next_sample pulses -> view_idx 0,1,2 with sample_out 0x11,0x22,0x33. Then prev_sample from 0 -> view_idx=2.
- OVERWRITE=1: write 0x01..0x07 -> full=1, count=5, oldest = 0x03, view_idx=4 showing 0x07. next_sample -> view_idx=0, 0x03 (checks head wrap past the physical end).
- OVERWRITE=0: write 0x01..0x06 -> 6th write gives overflow high exactly 1 cycle; contents 0x01..0x05 intact; count=5.
- Simultaneous events:
  - sample_in_valid with next_sample -> write taken, view moves to newest only.
  - next_sample with prev_sample -> no move.
  - clear with sample_in_valid -> count=0, no write.
- Reset deasserted-then-asserted mid-sequence (async, between clock edges) -> all outputs return to reset values immediately without waiting for a clock edge; the next write lands at logical index 0.

Source files
------------

// File: rtl/lap_stash.sv
// lap_stash: circular sample store with occupancy tracking and bidirectional browsing
module lap_stash #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter bit OVERWRITE = 1'b1,
  localparam int PTR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     sample_in,
  input  logic                 sample_in_valid,
  input  logic                 next_sample,
  input  logic                 prev_sample,
  input  logic                 clear,
  output logic [WIDTH-1:0]     sample_out,
  output logic [PTR_WIDTH-1:0] view_idx,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] head, head_nxt, view_nxt, wr_slot, rd_slot, last;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [CNT_WIDTH:0] wsum, rsum;
  logic we, ovf_nxt, nav_next, nav_prev;
  assign empty = count == '0;
  assign full = count == CNT_WIDTH'(DEPTH);
  // Slot addressing wraps by subtraction so non-power-of-two depths work; when full, head+count lands back on head
  always_comb begin
    wsum = (CNT_WIDTH+1)'(head) + (CNT_WIDTH+1)'(count);
    rsum = (CNT_WIDTH+1)'(head) + (CNT_WIDTH+1)'(view_idx);
    wr_slot = PTR_WIDTH'(wsum >= (CNT_WIDTH+1)'(DEPTH) ? wsum - (CNT_WIDTH+1)'(DEPTH) : wsum);
    rd_slot = PTR_WIDTH'(rsum >= (CNT_WIDTH+1)'(DEPTH) ? rsum - (CNT_WIDTH+1)'(DEPTH) : rsum);
    last = PTR_WIDTH'(count - CNT_WIDTH'(1));
    we = !clear && sample_in_valid && (!full || OVERWRITE);
    nav_next = next_sample && !prev_sample && !empty;
    nav_prev = prev_sample && !next_sample && !empty;
    view_nxt = clear ? '0 :
               sample_in_valid ? (full ? (OVERWRITE ? PTR_WIDTH'(DEPTH - 1) : view_idx) : PTR_WIDTH'(count)) :
               nav_next ? (view_idx == last ? '0 : view_idx + 1'b1) :
               nav_prev ? (view_idx == '0 ? last : view_idx - 1'b1) : view_idx;
    head_nxt = clear ? '0 : (we && full) ? (head == PTR_WIDTH'(DEPTH - 1) ? '0 : head + 1'b1) : head;
    cnt_nxt = clear ? '0 : (sample_in_valid && !full) ? count + 1'b1 : count;
    ovf_nxt = !clear && sample_in_valid && full && !OVERWRITE;
    sample_out = sample_in_valid ? sample_in : empty ? '0 : mem[rd_slot];
  end
  // Control registers: head, occupancy, view position and the drop pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      count <= '0;
      view_idx <= '0;
      overflow <= 1'b0;
    end else begin
      head <= head_nxt;
      count <= cnt_nxt;
      view_idx <= view_nxt;
      overflow <= ovf_nxt;
    end
  end
  // Sample storage; clear only rewinds pointers, contents survive it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_slot] <= sample_in;
    end
  end
endmodule

// File: tb/tb_lap_stash.sv
// tb_lap_stash: scoreboard bench for lap_stash in overwrite and drop configurations
module tb_lap_stash;
  logic clk, reset, v, nx, pv, clr;
  logic [7:0] din;
  logic [7:0] so_a, so_b;
  logic [2:0] vi_a, vi_b, cnt_a, cnt_b;
  logic em_a, em_b, fu_a, fu_b, ov_a, ov_b;
  logic [7:0] q[$];
  logic [7:0] e;
  int tests = 0;
  int fails = 0;

  lap_stash #(.WIDTH(8), .DEPTH(5), .OVERWRITE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .sample_in(din), .sample_in_valid(v), .next_sample(nx),
    .prev_sample(pv), .clear(clr), .sample_out(so_a), .view_idx(vi_a), .count(cnt_a),
    .empty(em_a), .full(fu_a), .overflow(ov_a));

  lap_stash #(.WIDTH(8), .DEPTH(5), .OVERWRITE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .sample_in(din), .sample_in_valid(v), .next_sample(nx),
    .prev_sample(pv), .clear(clr), .sample_out(so_b), .view_idx(vi_b), .count(cnt_b),
    .empty(em_b), .full(fu_b), .overflow(ov_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and check the view invariant on both instances
  task automatic tick;
    @(posedge clk);
    #1;
    tests++;
    if ((cnt_a != 0 && vi_a >= cnt_a) || (cnt_b != 0 && vi_b >= cnt_b)) begin
      fails++;
      $display("FAIL invariant view_a=%0d cnt_a=%0d view_b=%0d cnt_b=%0d", vi_a, cnt_a, vi_b, cnt_b);
    end
  endtask

  task automatic idle;
    v = 0; nx = 0; pv = 0; clr = 0;
  endtask

  task automatic do_clear;
    idle();
    clr = 1;
    tick();
    clr = 0;
    q.delete();
  endtask

  task automatic test_reset;
    reset = 0;
    din = 8'h00;
    idle();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({so_a, cnt_a, em_a, fu_a, ov_a} !== {8'h00, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got so=%h cnt=%0d em=%b fu=%b ov=%b exp 00/0/1/0/0", so_a, cnt_a, em_a, fu_a, ov_a);
    end
    reset = 1;
    tick();
    nx = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (vi_a !== 3'd0 || vi_b !== 3'd0) begin
        fails++;
        $display("FAIL empty_next got view_a=%0d view_b=%0d exp 0", vi_a, vi_b);
      end
    end
    nx = 0;
  endtask

  task automatic test_basic;
    logic [7:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    do_clear();
    for (int i = 0; i < 3; i++) begin
      din = vals[i];
      v = 1;
      q.push_back(vals[i]);
      #2;
      tests++;
      if (so_a !== vals[i]) begin
        fails++;
        $display("FAIL bypass got %h exp %h", so_a, vals[i]);
      end
      tick();
    end
    v = 0;
    #1;
    tests++;
    if ({cnt_a, vi_a, so_a} !== {3'd3, 3'd2, q[2]}) begin
      fails++;
      $display("FAIL after_writes got cnt=%0d view=%0d so=%h exp 3/2/%h", cnt_a, vi_a, so_a, q[2]);
    end
    nx = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = q[i];
      tests++;
      if (vi_a !== 3'(i) || so_a !== e) begin
        fails++;
        $display("FAIL browse_next got view=%0d so=%h exp %0d/%h", vi_a, so_a, i, e);
      end
    end
    tick();
    nx = 0;
    pv = 1;
    tick();
    pv = 0;
    tests++;
    if (vi_a !== 3'd2 || so_a !== q[2]) begin
      fails++;
      $display("FAIL prev_wrap got view=%0d so=%h exp 2/%h", vi_a, so_a, q[2]);
    end
  endtask

  task automatic test_overwrite;
    do_clear();
    v = 1;
    for (int i = 1; i <= 7; i++) begin
      din = 8'(i);
      q.push_back(8'(i));
      if (q.size() > 5) void'(q.pop_front());
      tick();
    end
    v = 0;
    #1;
    tests++;
    if ({fu_a, cnt_a, vi_a, so_a, ov_a} !== {1'b1, 3'd5, 3'd4, q[4], 1'b0}) begin
      fails++;
      $display("FAIL ovw_full got fu=%b cnt=%0d view=%0d so=%h ov=%b exp 1/5/4/%h/0", fu_a, cnt_a, vi_a, so_a, ov_a, q[4]);
    end
    nx = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = q[i];
      tests++;
      if (vi_a !== 3'(i) || so_a !== e) begin
        fails++;
        $display("FAIL ovw_browse got view=%0d so=%h exp %0d/%h", vi_a, so_a, i, e);
      end
    end
    nx = 0;
  endtask

  task automatic test_drop;
    do_clear();
    v = 1;
    for (int i = 1; i <= 5; i++) begin
      din = 8'(i);
      q.push_back(8'(i));
      tick();
    end
    tests++;
    if (ov_b !== 1'b0 || fu_b !== 1'b1) begin
      fails++;
      $display("FAIL drop_prefull got ov=%b fu=%b exp 0/1", ov_b, fu_b);
    end
    din = 8'h06;
    tick();
    v = 0;
    #1;
    tests++;
    if ({ov_b, cnt_b, vi_b, so_b, ov_a} !== {1'b1, 3'd5, 3'd4, q[4], 1'b0}) begin
      fails++;
      $display("FAIL drop_pulse got ov=%b cnt=%0d view=%0d so=%h ov_a=%b exp 1/5/4/%h/0", ov_b, cnt_b, vi_b, so_b, ov_a, q[4]);
    end
    tick();
    tests++;
    if (ov_b !== 1'b0) begin
      fails++;
      $display("FAIL drop_pulse_end got %b exp 0", ov_b);
    end
    nx = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = q[i];
      tests++;
      if (vi_b !== 3'(i) || so_b !== e) begin
        fails++;
        $display("FAIL drop_contents got view=%0d so=%h exp %0d/%h", vi_b, so_b, i, e);
      end
    end
    nx = 0;
  endtask

  task automatic test_simultaneous;
    do_clear();
    v = 1;
    din = 8'hA0;
    q.push_back(din);
    tick();
    din = 8'hB0;
    q.push_back(din);
    tick();
    v = 0;
    pv = 1;
    tick();
    pv = 0;
    tests++;
    if (vi_a !== 3'd0 || so_a !== q[0]) begin
      fails++;
      $display("FAIL prev_alone got view=%0d so=%h exp 0/%h", vi_a, so_a, q[0]);
    end
    din = 8'hC0;
    q.push_back(din);
    v = 1;
    nx = 1;
    tick();
    v = 0;
    nx = 0;
    #1;
    tests++;
    if ({cnt_a, vi_a, so_a} !== {3'd3, 3'd2, q[2]}) begin
      fails++;
      $display("FAIL write_with_next got cnt=%0d view=%0d so=%h exp 3/2/%h", cnt_a, vi_a, so_a, q[2]);
    end
    nx = 1;
    pv = 1;
    tick();
    nx = 0;
    pv = 0;
    tests++;
    if (vi_a !== 3'd2) begin
      fails++;
      $display("FAIL next_and_prev got view=%0d exp 2", vi_a);
    end
    clr = 1;
    v = 1;
    din = 8'hD0;
    tick();
    clr = 0;
    v = 0;
    #1;
    tests++;
    if ({cnt_a, vi_a, em_a, so_a} !== {3'd0, 3'd0, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL clear_with_write got cnt=%0d view=%0d em=%b so=%h exp 0/0/1/00", cnt_a, vi_a, em_a, so_a);
    end
  endtask

  task automatic test_async_reset;
    do_clear();
    v = 1;
    din = 8'h44;
    tick();
    din = 8'h55;
    tick();
    v = 0;
    #2;
    reset = 0;
    #1;
    tests++;
    if ({cnt_a, vi_a, em_a, fu_a, ov_a, so_a, cnt_b, so_b} !== {3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00}) begin
      fails++;
      $display("FAIL async_reset got cnt=%0d view=%0d em=%b fu=%b ov=%b so=%h cnt_b=%0d so_b=%h exp 0/0/1/0/0/00/0/00",
               cnt_a, vi_a, em_a, fu_a, ov_a, so_a, cnt_b, so_b);
    end
    #2;
    reset = 1;
    din = 8'h5A;
    v = 1;
    tick();
    v = 0;
    #1;
    tests++;
    if ({cnt_a, vi_a, so_a} !== {3'd1, 3'd0, 8'h5A}) begin
      fails++;
      $display("FAIL post_reset_write got cnt=%0d view=%0d so=%h exp 1/0/5a", cnt_a, vi_a, so_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overwrite();
    test_drop();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
